// File: rtl/slot_flag_tracker_pkg.sv
// Shared defaults for the slot flag tracker and its decoder.
// Every default parameter value of the tracker is taken from here.
package slot_flag_tracker_pkg;

   localparam int unsigned DefAddrWidth = 6;
   localparam int unsigned DefNumSlots  = 40;
   localparam int unsigned DefCntWidth  = 6;

endpackage

// File: rtl/onehot_decoder_en.sv
// Enabled address-to-one-hot decoder.
// The output is all zero when disabled or when the address is at or beyond NUM_SLOTS.
module onehot_decoder_en #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned NUM_SLOTS  = 40
) (
   input  logic                  en_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [NUM_SLOTS-1:0]  onehot_o
);

   // One extra bit so that NUM_SLOTS == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] NumSlotsW = (ADDR_WIDTH + 1)'(NUM_SLOTS);

   always_comb begin
      onehot_o = '0;
      if (en_i && ({1'b0, addr_i} < NumSlotsW)) begin
         onehot_o[addr_i] = 1'b1;
      end
   end

endmodule

// File: rtl/slot_flag_tracker.sv
// Per-slot occupancy flags with set/clear/flush, an incremental count,
// a lowest-free-slot finder and one-cycle error pulses.
module slot_flag_tracker
   import slot_flag_tracker_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned NUM_SLOTS  = DefNumSlots,
   parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  set_en_i,
   input  logic [ADDR_WIDTH-1:0] set_addr_i,
   input  logic                  clr_en_i,
   input  logic [ADDR_WIDTH-1:0] clr_addr_i,
   input  logic                  flush_i,
   output logic [NUM_SLOTS-1:0]  flags_o,
   output logic [NUM_SLOTS-1:0]  set_onehot_o,
   output logic [CNT_WIDTH-1:0]  count_o,
   output logic                  free_valid_o,
   output logic [ADDR_WIDTH-1:0] free_addr_o,
   output logic                  err_oob_o,
   output logic                  err_dup_o
);

   localparam logic [ADDR_WIDTH:0] NumSlotsW = (ADDR_WIDTH + 1)'(NUM_SLOTS);

   logic [NUM_SLOTS-1:0] set_oh, clr_oh;
   logic [NUM_SLOTS-1:0] flags_q, flags_d;
   logic [NUM_SLOTS-1:0] set_onehot_q, set_onehot_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 err_oob_q, err_oob_d;
   logic                 err_dup_q, err_dup_d;
   logic                 set_oob, clr_oob;
   logic                 set_dup, clr_dup;
   logic                 inc, dec;

   onehot_decoder_en #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SLOTS  (NUM_SLOTS)
   ) u_set_dec (
      .en_i     (set_en_i),
      .addr_i   (set_addr_i),
      .onehot_o (set_oh)
   );

   onehot_decoder_en #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SLOTS  (NUM_SLOTS)
   ) u_clr_dec (
      .en_i     (clr_en_i),
      .addr_i   (clr_addr_i),
      .onehot_o (clr_oh)
   );

   assign set_oob = set_en_i & ({1'b0, set_addr_i} >= NumSlotsW);
   assign clr_oob = clr_en_i & ({1'b0, clr_addr_i} >= NumSlotsW);

   // A set and clear of the same slot cancel each other's duplicate error.
   assign set_dup = |(set_oh & flags_q & ~clr_oh);
   assign clr_dup = |(clr_oh & ~flags_q & ~set_oh);
   assign inc     = |(set_oh & ~flags_q);
   assign dec     = |(clr_oh & flags_q & ~set_oh);

   always_comb begin
      flags_d      = (flags_q & ~clr_oh) | set_oh;
      set_onehot_d = set_oh;
      count_d      = count_q + CNT_WIDTH'(inc) - CNT_WIDTH'(dec);
      err_oob_d    = set_oob | clr_oob;
      err_dup_d    = set_dup | clr_dup;
      if (flush_i) begin
         flags_d      = '0;
         set_onehot_d = '0;
         count_d      = '0;
         err_oob_d    = 1'b0;
         err_dup_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flags_q      <= '0;
         set_onehot_q <= '0;
         count_q      <= '0;
         err_oob_q    <= 1'b0;
         err_dup_q    <= 1'b0;
      end else begin
         flags_q      <= flags_d;
         set_onehot_q <= set_onehot_d;
         count_q      <= count_d;
         err_oob_q    <= err_oob_d;
         err_dup_q    <= err_dup_d;
      end
   end

   // Scanning downwards leaves the lowest clear index as the final winner.
   always_comb begin
      free_addr_o = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!flags_q[i]) begin
            free_addr_o = ADDR_WIDTH'(i);
         end
      end
   end

   assign free_valid_o = ~&flags_q;
   assign flags_o      = flags_q;
   assign set_onehot_o = set_onehot_q;
   assign count_o      = count_q;
   assign err_oob_o    = err_oob_q;
   assign err_dup_o    = err_dup_q;

endmodule

// File: tb/tb_slot_flag_tracker.sv
// Bench for slot_flag_tracker: a 40-slot and a 16-slot instance run directed
// scenarios and random traffic against a rule-level reference model.
module tb_slot_flag_tracker;

   localparam int unsigned NA = 40, AWA = 6, CWA = 6;
   localparam int unsigned NB = 16, AWB = 4, CWB = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst[2], set_en[2], clr_en[2], flush[2];
   logic [AWA-1:0] sa0, ca0;
   logic [AWB-1:0] sa1, ca1;

   logic [NA-1:0]  a_flags, a_oh;
   logic [CWA-1:0] a_count;
   logic [AWA-1:0] a_fa;
   logic           a_fv, a_oob, a_dup;
   logic [NB-1:0]  b_flags, b_oh;
   logic [CWB-1:0] b_count;
   logic [AWB-1:0] b_fa;
   logic           b_fv, b_oob, b_dup;

   slot_flag_tracker #(.ADDR_WIDTH(AWA), .NUM_SLOTS(NA), .CNT_WIDTH(CWA)) u_dut_a (
      .clk_i        (clk),
      .rst_i        (rst[0]),
      .set_en_i     (set_en[0]),
      .set_addr_i   (sa0),
      .clr_en_i     (clr_en[0]),
      .clr_addr_i   (ca0),
      .flush_i      (flush[0]),
      .flags_o      (a_flags),
      .set_onehot_o (a_oh),
      .count_o      (a_count),
      .free_valid_o (a_fv),
      .free_addr_o  (a_fa),
      .err_oob_o    (a_oob),
      .err_dup_o    (a_dup)
   );

   slot_flag_tracker #(.ADDR_WIDTH(AWB), .NUM_SLOTS(NB), .CNT_WIDTH(CWB)) u_dut_b (
      .clk_i        (clk),
      .rst_i        (rst[1]),
      .set_en_i     (set_en[1]),
      .set_addr_i   (sa1),
      .clr_en_i     (clr_en[1]),
      .clr_addr_i   (ca1),
      .flush_i      (flush[1]),
      .flags_o      (b_flags),
      .set_onehot_o (b_oh),
      .count_o      (b_count),
      .free_valid_o (b_fv),
      .free_addr_o  (b_fa),
      .err_oob_o    (b_oob),
      .err_dup_o    (b_dup)
   );

   int unsigned n_slots[2] = '{NA, NB};
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model state: flag set as a bit vector, last-cycle pulses.
   bit [63:0] m_flags[2];
   bit [63:0] m_oh[2];
   bit        m_oob[2], m_dup[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] obs_flags(int d);
      return (d == 0) ? 64'(a_flags) : 64'(b_flags);
   endfunction
   function automatic logic [63:0] obs_oh(int d);
      return (d == 0) ? 64'(a_oh) : 64'(b_oh);
   endfunction
   function automatic logic [63:0] obs_count(int d);
      return (d == 0) ? 64'(a_count) : 64'(b_count);
   endfunction
   function automatic logic [63:0] obs_fa(int d);
      return (d == 0) ? 64'(a_fa) : 64'(b_fa);
   endfunction
   function automatic logic obs_fv(int d);
      return (d == 0) ? a_fv : b_fv;
   endfunction
   function automatic logic obs_oob(int d);
      return (d == 0) ? a_oob : b_oob;
   endfunction
   function automatic logic obs_dup(int d);
      return (d == 0) ? a_dup : b_dup;
   endfunction

   task automatic drive(int d, bit r, bit fl, bit se, int sa, bit ce, int ca);
      rst[d]    = r;
      flush[d]  = fl;
      set_en[d] = se;
      clr_en[d] = ce;
      if (d == 0) begin
         sa0 = AWA'(sa);
         ca0 = AWA'(ca);
      end else begin
         sa1 = AWB'(sa);
         ca1 = AWB'(ca);
      end
   endtask

   task automatic idle_all();
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic model_step(int d);
      int unsigned sa, ca, n;
      bit sv, cv, same;
      n  = n_slots[d];
      sa = (d == 0) ? int'(sa0) : int'(sa1);
      ca = (d == 0) ? int'(ca0) : int'(ca1);
      if (rst[d] || flush[d]) begin
         m_flags[d] = '0;
         m_oh[d]    = '0;
         m_oob[d]   = 1'b0;
         m_dup[d]   = 1'b0;
      end else begin
         sv       = set_en[d] && (sa < n);
         cv       = clr_en[d] && (ca < n);
         same     = sv && cv && (sa == ca);
         m_oob[d] = (set_en[d] && !sv) || (clr_en[d] && !cv);
         m_dup[d] = (sv && !same && m_flags[d][sa]) || (cv && !same && !m_flags[d][ca]);
         if (cv) m_flags[d][ca] = 1'b0;
         if (sv) m_flags[d][sa] = 1'b1;
         m_oh[d] = sv ? (64'd1 << sa) : 64'd0;
      end
   endtask

   task automatic compare(int d);
      bit        fv = 1'b0;
      int        fa = 0;
      for (int i = int'(n_slots[d]) - 1; i >= 0; i--) begin
         if (!m_flags[d][i]) begin
            fv = 1'b1;
            fa = i;
         end
      end
      check($sformatf("flags[%0d]", d), obs_flags(d), m_flags[d]);
      check($sformatf("set_onehot[%0d]", d), obs_oh(d), m_oh[d]);
      check($sformatf("count[%0d]", d), obs_count(d), 64'($countones(m_flags[d])));
      check($sformatf("free_valid[%0d]", d), 64'(obs_fv(d)), 64'(fv));
      check($sformatf("free_addr[%0d]", d), obs_fa(d), 64'(fa));
      check($sformatf("err_oob[%0d]", d), 64'(obs_oob(d)), 64'(m_oob[d]));
      check($sformatf("err_dup[%0d]", d), 64'(obs_dup(d)), 64'(m_dup[d]));
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      compare(0);
      compare(1);
   endtask

   task automatic scenarios(int d);
      int unsigned top, c;
      top = n_slots[d] - 1;
      c   = (n_slots[d] > 17) ? 17 : n_slots[d] - 2;
      idle_all();
      drive(d, 1, 0, 0, 0, 0, 0); tick();
      check($sformatf("rst_free_valid[%0d]", d), 64'(obs_fv(d)), 64'd1);
      check($sformatf("rst_free_addr[%0d]", d), obs_fa(d), 64'd0);
      // Sets at 0, 1 and the top slot.
      drive(d, 0, 0, 1, 0, 0, 0); tick();
      check($sformatf("s1_oh0[%0d]", d), obs_oh(d), 64'd1);
      drive(d, 0, 0, 1, 1, 0, 0); tick();
      drive(d, 0, 0, 1, int'(top), 0, 0); tick();
      check($sformatf("s1_ohtop[%0d]", d), obs_oh(d), 64'd1 << top);
      drive(d, 0, 0, 0, 0, 0, 0); tick();
      check($sformatf("s1_flags[%0d]", d), obs_flags(d), (64'd1 << top) | 64'd3);
      check($sformatf("s1_count[%0d]", d), obs_count(d), 64'd3);
      check($sformatf("s1_free[%0d]", d), obs_fa(d), 64'd2);
      // Duplicate set, then set and clear of the same slot.
      drive(d, 0, 0, 1, 5, 0, 0); tick();
      drive(d, 0, 0, 1, 5, 0, 0); tick();
      check($sformatf("s2_dup[%0d]", d), 64'(obs_dup(d)), 64'd1);
      check($sformatf("s2_count[%0d]", d), obs_count(d), 64'd4);
      drive(d, 0, 0, 1, 5, 1, 5); tick();
      check($sformatf("s2_same_dup[%0d]", d), 64'(obs_dup(d)), 64'd0);
      check($sformatf("s2_flag5[%0d]", d), 64'(obs_flags(d)[5]), 64'd1);
      // Out-of-range set (only reachable on the wide instance).
      if (d == 0) begin
         drive(d, 0, 0, 1, 45, 0, 0); tick();
         check("s3_oob[0]", 64'(obs_oob(d)), 64'd1);
         check("s3_oh[0]", obs_oh(d), 64'd0);
      end else begin
         drive(d, 0, 0, 0, 0, 1, 15); tick();
         drive(d, 0, 0, 1, 15, 0, 0); tick();
         check("s3_oh15[1]", obs_oh(d), 64'h8000);
      end
      // Fill every slot, then free one.
      for (int i = 0; i < int'(n_slots[d]); i++) begin
         drive(d, 0, 0, 1, i, 0, 0); tick();
      end
      check($sformatf("s4_count[%0d]", d), obs_count(d), 64'(n_slots[d]));
      check($sformatf("s4_fv[%0d]", d), 64'(obs_fv(d)), 64'd0);
      check($sformatf("s4_fa[%0d]", d), obs_fa(d), 64'd0);
      drive(d, 0, 0, 0, 0, 1, int'(c)); tick();
      check($sformatf("s4_fa_clr[%0d]", d), obs_fa(d), 64'(c));
      check($sformatf("s4_count_clr[%0d]", d), obs_count(d), 64'(n_slots[d] - 1));
      // Flush beats a set; reset beats a duplicate set.
      drive(d, 0, 1, 1, 3, 0, 0); tick();
      check($sformatf("s5_flush_flags[%0d]", d), obs_flags(d), 64'd0);
      check($sformatf("s5_flush_oh[%0d]", d), obs_oh(d), 64'd0);
      drive(d, 0, 0, 1, 7, 0, 0); tick();
      drive(d, 1, 0, 1, 7, 1, 2); tick();
      check($sformatf("s5_rst_flags[%0d]", d), obs_flags(d), 64'd0);
      check($sformatf("s5_rst_count[%0d]", d), obs_count(d), 64'd0);
      check($sformatf("s5_rst_oh[%0d]", d), obs_oh(d), 64'd0);
      check($sformatf("s5_rst_err[%0d]", d), 64'({obs_oob(d), obs_dup(d)}), 64'd0);
      drive(d, 0, 0, 0, 0, 0, 0); tick();
   endtask

   initial begin
      idle_all();
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      tick();
      scenarios(0);
      scenarios(1);
      for (int k = 0; k < 600; k++) begin
         for (int d = 0; d < 2; d++) begin
            drive(d, ($urandom_range(0, 99) == 0), ($urandom_range(0, 31) == 0),
                  $urandom_range(0, 3) != 0, int'($urandom_range(0, (d == 0) ? 47 : 15)),
                  $urandom_range(0, 2) == 0, int'($urandom_range(0, (d == 0) ? 47 : 15)));
         end
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/slot_flag_tracker.md
SLOT_FLAG_TRACKER -- requirements
Module: slot_flag_tracker

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, slot address width.
REQ-002 SHALL have parameter NUM_SLOTS, default 40, number of slots; legal range 2..2^ADDR_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 6, width of the occupancy count; it must be at least clog2(NUM_SLOTS+1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 set_en  input  1  request to set the flag of slot set_addr.
REQ-007 set_addr  input  ADDR_WIDTH  slot to set.
REQ-008 clr_en  input  1  request to clear the flag of slot clr_addr.
REQ-009 clr_addr  input  ADDR_WIDTH  slot to clear.
REQ-010 flush  input  1  clear all flags.
REQ-011 flags  output  NUM_SLOTS  registered per-slot flag vector.
REQ-012 set_onehot  output  NUM_SLOTS  registered one-cycle one-hot pulse of the accepted set.
REQ-013 count  output  CNT_WIDTH  registered number of flags that are 1.
REQ-014 free_valid  output  1  at least one flag is 0.
REQ-015 free_addr  output  ADDR_WIDTH  lowest-index slot whose flag is 0; 0 when free_valid=0.
REQ-016 err_oob  output  1  registered pulse: a set or clear address was >= NUM_SLOTS.
REQ-017 err_dup  output  1  registered pulse: a set targeted an already-set slot, or a clear targeted an already-clear slot.

Function
REQ-018 All register outputs SHALL update exactly 1 cycle after the inputs are sampled; free_valid and free_addr SHALL be combinational from flags.
REQ-019 Each cycle, the next flags SHALL be computed in this order: flush, then clear, then set.
REQ-020 When flush=1, the next flags SHALL be all 0 and set_en/clr_en SHALL be ignored for that cycle; set_onehot and both error outputs SHALL then be 0.
REQ-021 A set with set_addr < NUM_SLOTS SHALL be accepted: the flag becomes 1 and set_onehot[set_addr] pulses for 1 cycle.
REQ-022 A set whose target flag is already 1 and is not cleared in the same cycle SHALL leave flags unchanged, still pulse set_onehot, and assert err_dup.
REQ-023 A clear with clr_addr < NUM_SLOTS SHALL set that flag to 0; if the flag is already 0, err_dup SHALL be asserted.
REQ-024 A set and a clear of the same slot in the same cycle SHALL leave the flag at 1, with no err_dup for either request.
REQ-025 A set and a clear of different slots in the same cycle SHALL both take effect.
REQ-026 Any address >= NUM_SLOTS SHALL be ignored, and err_oob SHALL pulse for 1 cycle.
REQ-027 set_onehot SHALL be 0 whenever set_en=0, flush=1, or set_addr is out of range.
REQ-028 count SHALL always equal the popcount of flags in the same cycle; it is updated incrementally by +1, -1 or 0, or set to 0 on flush, with no wrap.
REQ-029 With all flags 1: free_valid=0 and free_addr=0; a further set SHALL give err_dup and no change.

Reset
REQ-030 When rst=1 at a clock edge, the next state SHALL be flags=0, set_onehot=0, count=0, err_oob=0 and err_dup=0, regardless of all other inputs.
REQ-031 Reset asserted mid-operation, including in the same cycle as a set, clear or flush, SHALL override everything.
REQ-032 Immediately after reset: free_valid=1 and free_addr=0.

Structure
REQ-033 Default ADDR_WIDTH, NUM_SLOTS and CNT_WIDTH SHALL be defined in the shared global definitions include and used as the parameter defaults.
REQ-034 One sub-module, onehot_decoder_en, SHALL be used twice (once for set, once for clear). It is parametrised by ADDR_WIDTH and NUM_SLOTS, combinational, and outputs all 0 when en=0 or the address is out of range.
REQ-035 The lowest-free-slot priority encoder SHALL be written inline in this module; no further sub-modules.

Verification
REQ-036 Reset, then set 0, 1, 39 on consecutive cycles -> flags bits {0,1,39}=1, count=3, free_addr=2, set_onehot pulses at bits 0, 1, 39.
REQ-037 Set 5 while 5 is already set -> err_dup=1 for 1 cycle, count unchanged; then set 5 and clear 5 in the same cycle -> flag 5=1, no error.
REQ-038 set_addr=45 (NUM_SLOTS=40) -> err_oob=1 for 1 cycle, flags unchanged, set_onehot=0.
REQ-039 Fill all 40 slots -> count=40, free_valid=0; clear 17 -> free_addr=17 and count=39 on the next cycle.
REQ-040 Flush together with set 3 -> flags=0, count=0, set_onehot=0; rst together with set 7 -> all outputs 0.
REQ-041 Re-run scenarios REQ-036 to REQ-040 with NUM_SLOTS=16, ADDR_WIDTH=4; set_addr=15 must be accepted.
